// File: rtl/mem_access_arbiter.sv
// Sequenced arbiter sharing the single MMU/SRAM port between instruction fetch and MEM-stage data.
// Each access holds the MMU command for WAIT_CYCLES cycles, then acks the owner for one cycle.
module mem_access_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic              mmu_read,
    output logic              mmu_write,
    output logic              mmu_bytemode,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [31:0]       mmu_wdata,
    input  logic [31:0]       mmu_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [2:0] CntLoad = 3'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;        // 1 = MEM, 0 = IF
    logic              last_mem_q, last_mem_d;  // previous completed owner was MEM
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              byte_mode_q, byte_mode_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              grant_mem;

    // MEM has priority unless it was served last and IF is waiting.
    assign grant_mem = mem_req & ~(last_mem_q & if_req);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_mem_d  = last_mem_q;
        addr_d      = addr_q;
        we_d        = we_q;
        byte_mode_d = byte_mode_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req || if_req) begin
                    owner_d     = grant_mem;
                    addr_d      = grant_mem ? mem_addr : if_addr;
                    we_d        = grant_mem & mem_we;
                    byte_mode_d = grant_mem & mem_byte;
                    wdata_d     = grant_mem ? mem_wdata : wdata_q;
                    cnt_d       = CntLoad;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 3'd0) begin
                    if (!we_q) begin
                        if (owner_q) mem_rdata_d = mmu_rdata;
                        else         if_rdata_d  = mmu_rdata;
                    end
                    last_mem_d = owner_q;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_mem_q  <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            byte_mode_q <= 1'b0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_mem_q  <= last_mem_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            byte_mode_q <= byte_mode_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Strobes follow the state; address and write data stay at their last latched value.
    assign mmu_read     = (state_q == StAccess) & ~we_q;
    assign mmu_write    = (state_q == StAccess) & we_q;
    assign mmu_bytemode = (state_q == StAccess) & byte_mode_q;
    assign mmu_addr     = addr_q;
    assign mmu_wdata    = wdata_q;

    assign if_ack    = (state_q == StResp) & ~owner_q;
    assign mem_ack   = (state_q == StResp) & owner_q;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: table-driven single transactions plus
// arbitration, mid-access reset and single-wait-cycle sequences.
module tb_mem_access_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, mem_byte;
    logic [31:0] if_addr, mem_addr, mem_wdata, mmu_rdata;
    logic [31:0] if_rdata, mem_rdata, mmu_addr, mmu_wdata;
    logic        if_ack, if_stall, mem_ack, mem_stall;
    logic        mmu_read, mmu_write, mmu_bytemode, busy;

    logic        w1_if_req, w1_mem_req, w1_mem_we, w1_mem_byte;
    logic [31:0] w1_if_addr, w1_mem_addr, w1_mem_wdata, w1_mmu_rdata;
    logic [31:0] w1_if_rdata, w1_mem_rdata, w1_mmu_addr, w1_mmu_wdata;
    logic        w1_if_ack, w1_if_stall, w1_mem_ack, w1_mem_stall;
    logic        w1_mmu_read, w1_mmu_write, w1_mmu_bytemode, w1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_bytemode(mmu_bytemode),
        .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata), .busy(busy)
    );

    mem_access_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32)) dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
        .if_stall(w1_if_stall),
        .mem_req(w1_mem_req), .mem_we(w1_mem_we), .mem_byte(w1_mem_byte),
        .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata),
        .mem_ack(w1_mem_ack), .mem_stall(w1_mem_stall),
        .mmu_read(w1_mmu_read), .mmu_write(w1_mmu_write), .mmu_bytemode(w1_mmu_bytemode),
        .mmu_addr(w1_mmu_addr), .mmu_wdata(w1_mmu_wdata), .mmu_rdata(w1_mmu_rdata),
        .busy(w1_busy)
    );

    typedef struct packed {
        logic        is_mem;
        logic        we;
        logic        bmode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Single request from IDLE, held until its ack, then dropped.
    task automatic run_txn(input vec_t v, input string tag);
        int   lat, rd_cnt, wr_cnt, by_cnt, bus_bad, stall_bad, wrong_ack;
        logic got, stall_at_ack;
        lat = 0; rd_cnt = 0; wr_cnt = 0; by_cnt = 0;
        bus_bad = 0; stall_bad = 0; wrong_ack = 0;
        got = 1'b0; stall_at_ack = 1'b1;
        @(posedge clk); #1;
        mmu_rdata = v.rdata;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_byte = v.bmode;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mmu_read)     rd_cnt++;
            if (mmu_write)    wr_cnt++;
            if (mmu_bytemode) by_cnt++;
            if ((mmu_read || mmu_write) && mmu_addr !== v.addr) bus_bad++;
            if (mmu_write && mmu_wdata !== v.wdata) bus_bad++;
            if (v.is_mem ? if_ack : mem_ack) wrong_ack++;
            if (v.is_mem ? mem_ack : if_ack) begin
                got = 1'b1;
                stall_at_ack = v.is_mem ? mem_stall : if_stall;
            end else if (!(v.is_mem ? mem_stall : if_stall)) begin
                stall_bad++;
            end
        end
        check({tag, " latency"}, lat, W + 2);
        check({tag, " read cycles"}, rd_cnt, v.we ? 0 : W);
        check({tag, " write cycles"}, wr_cnt, v.we ? W : 0);
        check({tag, " byte cycles"}, by_cnt, v.bmode ? W : 0);
        check({tag, " bus addr/wdata"}, bus_bad, 0);
        check({tag, " stall before ack"}, stall_bad, 0);
        check({tag, " stall at ack"}, {31'd0, stall_at_ack}, 0);
        check({tag, " other ack"}, wrong_ack, 0);
        check({tag, " if_rdata"}, if_rdata, v.exp_if_rdata);
        check({tag, " mem_rdata"}, mem_rdata, v.exp_mem_rdata);
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    initial begin
        int   n, cyc, lat, rd, acks, consec;
        logic seq[4];
        logic got;
        vec_t fresh;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h3C01_1234,
                    32'h3C01_1234, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h8040_0010, 32'h0000_00AB, 32'h1111_1111,
                    32'h3C01_1234, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h8040_0020, 32'h0, 32'hCAFE_F00D,
                    32'h3C01_1234, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8040_0024, 32'h1234_5678, 32'h5555_5555,
                    32'h3C01_1234, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 32'h2402_0005,
                    32'h2402_0005, 32'hCAFE_F00D};

        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0; mem_byte = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mmu_rdata = 0;
        w1_if_req = 0; w1_mem_req = 0; w1_mem_we = 0; w1_mem_byte = 0;
        w1_if_addr = 0; w1_mem_addr = 0; w1_mem_wdata = 0; w1_mmu_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 0);
        check("reset strobes", {29'd0, mmu_read, mmu_write, mmu_bytemode}, 0);
        check("reset acks", {30'd0, if_ack, mem_ack}, 0);
        check("reset mmu_addr", mmu_addr, 0);
        check("reset mmu_wdata", mmu_wdata, 0);
        check("reset rdata", if_rdata | mem_rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Both requesting continuously after an IF grant: MEM, IF, MEM, IF.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h8000_0008;
        mem_req = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h8040_0030;
        mmu_rdata = 32'h0F0F_0F0F;
        n = 0; cyc = 0; consec = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_ack && if_ack) consec++;
            if (mem_ack) begin
                if (n > 0 && seq[n-1]) consec++;
                seq[n] = 1'b1; n++;
            end else if (if_ack) begin
                seq[n] = 1'b0; n++;
            end
        end
        check("arb ack count", n, 4);
        check("arb total cycles", cyc, 4 * (W + 2));
        check("arb grant0 MEM", {31'd0, seq[0]}, 1);
        check("arb grant1 IF", {31'd0, seq[1]}, 0);
        check("arb grant2 MEM", {31'd0, seq[2]}, 1);
        check("arb grant3 IF", {31'd0, seq[3]}, 0);
        check("arb consecutive MEM", consec, 0);
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;

        // Reset during the second ACCESS cycle aborts with no ack.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h8000_0100; mmu_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        @(negedge clk);
        check("abort first access read", {31'd0, mmu_read}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort mmu_read", {31'd0, mmu_read}, 0);
        check("abort busy", {31'd0, busy}, 0);
        check("abort if_rdata", if_rdata, 0);
        check("abort mmu_addr", mmu_addr, 0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_ack || mem_ack || busy) acks++;
        end
        check("abort no ack after reset", acks, 0);
        fresh = '{1'b0, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 32'h2108_0001, 32'h2108_0001, 32'h0};
        run_txn(fresh, "post-reset fetch");

        // Single wait cycle: load acks three cycles after request.
        @(posedge clk); #1;
        w1_mem_req = 1'b1; w1_mem_we = 1'b0; w1_mem_byte = 1'b0;
        w1_mem_addr = 32'h8040_0040; w1_mmu_rdata = 32'hDEAD_BEEF;
        lat = 0; rd = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (w1_mmu_read) rd++;
            if (w1_mem_ack) got = 1'b1;
        end
        check("w1 latency", lat, 3);
        check("w1 read cycles", rd, 1);
        check("w1 mem_rdata", w1_mem_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        w1_mem_req = 1'b0;
        @(negedge clk);
        check("w1 idle after ack", {30'd0, w1_busy, w1_mem_ack}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single MMU/SRAM port between the instruction-fetch requester and the MEM-stage data requester.
- Replaces the combinational IF/MEM address mux with a sequenced, multi-cycle access controller.
- Provides registered read data, one-cycle acknowledges and per-requester stall signals to the pipeline.
- Sits between the IF/MEM stages and the MMU, in the CPU clock domain.

Parameters:
- WAIT_CYCLES, 2: cycles the MMU command is held per access; legal range 1..7.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  CPU clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_ack (combinational).
- mem_req  in  1  data request; held high until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_byte  in  1  byte-mode access.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle data completion pulse.
- mem_stall  out  1  mem_req & ~mem_ack (combinational).
- mmu_read  out  1  MMU read strobe.
- mmu_write  out  1  MMU write strobe.
- mmu_bytemode  out  1  MMU byte mode.
- mmu_addr  out  ADDR_W  MMU address.
- mmu_wdata  out  32  MMU write data.
- mmu_rdata  in  32  MMU read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset:
- State returns to IDLE. All outputs go to 0: mmu_read, mmu_write, mmu_bytemode, mmu_addr, mmu_wdata, if_ack, mem_ack, if_rdata, mem_rdata, busy.
- last_grant resets to IF.
- Reset asserted mid-access aborts the access immediately. No ack is issued and nothing is retried.

States: IDLE, ACCESS, RESP.

IDLE:
- Arbitration: grant MEM if mem_req, except when last_grant=MEM and if_req=1, in which case grant IF. Otherwise grant IF if if_req.
- On a grant: latch owner, address, we, byte and wdata into registers; load counter with WAIT_CYCLES-1; go to ACCESS.
- An IF grant always uses read, word mode.

ACCESS:
- Drive the MMU from the latched registers: mmu_read = ~we, mmu_write = we, mmu_bytemode = byte.
- Counter decrements each cycle. When it reaches 0:
  - capture mmu_rdata into the owner's rdata register (loads and fetches only; rdata is unchanged for stores);
  - deassert mmu_read and mmu_write;
  - set last_grant to the owner;
  - go to RESP.
- Requester inputs changing during ACCESS are ignored.

RESP:
- Assert the owner's ack for exactly one cycle, then go to IDLE.
- A new arbitration happens in IDLE on the following cycle.

Latency and rdata:
- Request-to-ack latency from IDLE is WAIT_CYCLES+2 cycles (grant edge, WAIT_CYCLES access cycles, ack cycle).
- rdata registers hold their value until the next completed access of the same owner.

Requester rules and boundaries:
- A requester must drop req in the cycle after ack. A req still high in IDLE counts as a new request.
- Simultaneous if_req and mem_req from IDLE: MEM wins unless last_grant=MEM. MEM therefore never receives two consecutive grants while IF is waiting.
- A req deasserted before grant is simply not serviced.
- mmu_addr and mmu_wdata keep their last latched values when idle; only the strobes are cleared.
- Setting WAIT_CYCLES=1 gives a single ACCESS cycle.

Test Plan:
1. Reset, then if_req=1, if_addr=0x80000000, mmu_rdata=0x3C011234 -> mmu_read=1 for 2 cycles; if_ack pulses on cycle 4 with if_rdata=0x3C011234; if_stall=1 on cycles 1-3.
2. Store: mem_req=1, mem_we=1, mem_byte=1, mem_addr=0x80400010, mem_wdata=0xAB -> mmu_write=1, mmu_bytemode=1, mmu_addr=0x80400010 for 2 cycles; mem_ack pulses once; mmu_read stays 0.
3. if_req and mem_req both high from IDLE with last_grant=IF -> MEM is served first; IF is served next; the third grant goes to MEM if both are still requesting.
4. mem_req held high continuously with if_req high -> grants alternate MEM, IF, MEM; no two consecutive MEM acks.
5. rst asserted during the second ACCESS cycle -> mmu_read=0 and busy=0 immediately; no ack issued; a fresh if_req after reset completes normally.
6. WAIT_CYCLES=1, load with mmu_rdata=0xDEADBEEF -> mem_ack arrives 3 cycles after mem_req with mem_rdata=0xDEADBEEF.
